// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types for the RV32M iterative multiply/divide unit.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package ex_muldiv_unit_pkg;

  // Iteration count of the shift datapath for a 32-bit machine.
  localparam int MULDIV_ITERS = 32;

  // Encoding matches funct3 of the M-extension instructions.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_state_t;

  // funct3[2] separates divide/remainder from multiply.
  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // Remainder ops return the remainder, all other divides the quotient.
  function automatic logic op_is_rem(input muldiv_op_t op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // MUL low word is signedness-independent, so it runs on raw unsigned operands.
  function automatic logic op_a_signed(input muldiv_op_t op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide.
// Latency: 34 edges from the start-sampling edge to done (1 edge for div-by-zero / overflow).
// Backpressure: stall holds the front of the pipeline while busy; flush kills the op silently.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_idx,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_idx_out
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  SIGN_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};

  md_state_t        state_q, state_d;
  muldiv_op_t       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]  hi_q, hi_d;       // product high half / partial remainder
  logic [XLEN-1:0]  lo_q, lo_d;       // multiplier -> product low / dividend -> quotient
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             done_q, done_d;

  // Operand conditioning in IDLE: sign detection and magnitudes.
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf;

  always_comb begin
    a_neg       = op_a_signed(op) & rs1_data[XLEN-1];
    b_neg       = op_b_signed(op) & rs2_data[XLEN-1];
    a_mag       = a_neg ? (~rs1_data + 1'b1) : rs1_data;
    b_mag       = b_neg ? (~rs2_data + 1'b1) : rs2_data;
    div_by_zero = op_is_div(op) && (rs2_data == '0);
    div_ovf     = ((op == MD_DIV) || (op == MD_REM)) &&
                  (rs1_data == SIGN_MIN) && (rs2_data == ALL_ONES);
  end

  // One iteration of the shared shift datapath (multiply or restoring divide).
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_ge;
  logic [XLEN-1:0] div_sub;
  logic [XLEN-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    // True difference is below the divisor, so the low XLEN bits are exact.
    div_sub   = div_shift[XLEN-1:0] - opnd_q;
    if (op_is_div(op_q)) begin
      step_hi = div_ge ? div_sub : div_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and final selection of the architectural result.
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN-1:0]   fix_result;

  always_comb begin
    prod_raw = {hi_q, lo_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? (~prod_raw + 1'b1) : prod_raw;
    quo_fix  = (sign_a_q ^ sign_b_q) ? (~lo_q + 1'b1) : lo_q;
    // Remainder takes the sign of the dividend.
    rem_fix  = sign_a_q ? (~hi_q + 1'b1) : hi_q;
    if (op_is_div(op_q)) begin
      fix_result = op_is_rem(op_q) ? rem_fix : quo_fix;
    end else if (op_q == MD_MUL) begin
      fix_result = prod_fix[XLEN-1:0];
    end else begin
      fix_result = prod_fix[2*XLEN-1:XLEN];
    end
  end

  // Next-state and next-register computation for the control FSM.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    result_d = result_q;

    if (flush) begin
      state_d = MD_IDLE;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (start) begin
            op_d     = op;
            rd_d     = rd_idx;
            sign_a_d = a_neg;
            sign_b_d = b_neg;
            cnt_d    = '0;
            if (div_by_zero) begin
              result_d = op_is_rem(op) ? rs1_data : ALL_ONES;
              rd_out_d = rd_idx;
              state_d  = MD_DONE;
            end else if (div_ovf) begin
              result_d = op_is_rem(op) ? '0 : SIGN_MIN;
              rd_out_d = rd_idx;
              state_d  = MD_DONE;
            end else begin
              hi_d    = '0;
              opnd_d  = op_is_div(op) ? b_mag : a_mag;
              lo_d    = op_is_div(op) ? a_mag : b_mag;
              state_d = MD_CALC;
            end
          end
        end
        MD_CALC: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d = MD_FIX;
          end
        end
        MD_FIX: begin
          result_d = fix_result;
          rd_out_d = rd_q;
          state_d  = MD_DONE;
        end
        MD_DONE: begin
          // A start still asserted for the retiring instruction is ignored here.
          state_d = MD_IDLE;
        end
        default: state_d = MD_IDLE;
      endcase
    end

    done_d = (state_d == MD_DONE);
  end

  // All FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      op_q     <= MD_MUL;
      rd_q     <= '0;
      rd_out_q <= '0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Stall drops in DONE so the pipeline advances on the retiring edge.
  always_comb begin
    stall = ((state_q == MD_IDLE) && start && !flush) ||
            (state_q == MD_CALC) || (state_q == MD_FIX);
  end

  assign done       = done_q;
  assign result     = result_q;
  assign rd_idx_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with a queue-based scoreboard.
// Stimulus pushes the expected {rd, result}; a negedge monitor pops on every done.
// Latency, stall, flush and async-reset behaviour are checked inline.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            start;
  muldiv_op_t      op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_idx;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_idx_out;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .start      (start),
    .op         (op),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rd_idx     (rd_idx),
    .stall      (stall),
    .done       (done),
    .result     (result),
    .rd_idx_out (rd_idx_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] res;
    string           nm;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_bad;

  task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done with rd=%0d result=0x%08h expected none", rd_idx_out, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.nm, "_result"}, result, e.res);
        check({e.nm, "_rd"}, {27'd0, rd_idx_out}, {27'd0, e.rd});
      end
    end
  end

  // Issue one instruction, hold start as the ID/EX register would, and check timing.
  task automatic run_op(input muldiv_op_t o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [4:0] rd, input logic [XLEN-1:0] exp_res,
                        input int exp_lat, input string nm);
    int edges;
    int stalls;
    bit seen;
    @(negedge clk);
    op       = o;
    rs1_data = a;
    rs2_data = b;
    rd_idx   = rd;
    start    = 1'b1;
    sb.push_back('{rd, exp_res, nm});
    #1;
    check({nm, "_stall_at_start"}, {31'd0, stall}, 32'd1);
    edges  = 0;
    stalls = 0;
    seen   = 1'b0;
    while (!seen && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) seen = 1'b1;
      else if (stall) stalls++;
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got no done after %0d edges expected done", nm, edges);
      void'(sb.pop_back());
    end else begin
      check({nm, "_latency"}, edges, exp_lat);
      check({nm, "_stall_cycles"}, stalls, exp_lat - 1);
    end
    // Keep start high across the retiring edge: it must not relaunch the op.
    @(posedge clk);
    #1;
    start = 1'b0;
    check({nm, "_done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    logic [XLEN-1:0] held;
    n_vec    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    flush    = 1'b0;
    start    = 1'b0;
    op       = MD_MUL;
    rs1_data = '0;
    rs2_data = '0;
    rd_idx   = '0;

    repeat (3) @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_rd", {27'd0, rd_idx_out}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;

    // Multiplies: 34 edges including the start-sampling edge.
    run_op(MD_MUL,    32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 34, "mul_7x-3");
    run_op(MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 34, "mulh_min_min");
    run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 34, "mulhu_max_max");
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd4,  32'hFFFF_FFFF, 34, "mulhsu_-1x2");
    // Divides.
    run_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,         5'd5,  32'hFFFF_FFFD, 34, "div_-7/2");
    run_op(MD_REM,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 34, "rem_-7/2");
    run_op(MD_DIVU,   32'd100,       32'd7,         5'd7,  32'd14,        34, "divu_100/7");
    run_op(MD_REMU,   32'd100,       32'd7,         5'd8,  32'd2,         34, "remu_100/7");
    // Special cases complete on the start-sampling edge.
    run_op(MD_DIVU,   32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1,  "divu_5/0");
    run_op(MD_REM,    32'd5,         32'd0,         5'd10, 32'd5,         1,  "rem_5/0");
    run_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1,  "div_ovf");
    run_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1,  "rem_ovf");

    // Flush ten edges into CALC: no done, stall drops, result held.
    held = 32'd0;
    @(negedge clk);
    op       = MD_MUL;
    rs1_data = 32'd1000;
    rs2_data = 32'd1000;
    rd_idx   = 5'd13;
    start    = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result_held", result, 32'd0);
    check("flush_rd_held", {27'd0, rd_idx_out}, 32'd12);
    @(negedge clk);
    flush    = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("flush_no_done", done_cnt, 0);
    run_op(MD_MUL, 32'd3, 32'd4, 5'd14, 32'd12, 34, "mul_3x4_after_flush");

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    op       = MD_DIVU;
    rs1_data = 32'd50;
    rs2_data = 32'd5;
    rd_idx   = 5'd15;
    start    = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, held);
    check("arst_rd", {27'd0, rd_idx_out}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back divide then multiply.
    run_op(MD_DIV, 32'd1000, 32'hFFFF_FFF6, 5'd16, 32'hFFFF_FF9C, 34, "b2b_div_1000/-10");
    run_op(MD_MUL, 32'd123,  32'hFFFF_FFFF, 5'd17, 32'hFFFF_FF85, 34, "b2b_mul_123x-1");

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
